cargo_stop_scheduler: RTL

CARGO_STOP_SCHEDULER -- requirements
Module: cargo_stop_scheduler

---
 rtl/cargo_stop_scheduler.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/cargo_stop_scheduler.sv
// Cargo elevator stop scheduler.
// Keeps a 4-entry table of pickup/drop orders, services the current floor on
// parada_concluida, and runs a sweep (SCAN-style) direction FSM that picks the
// next floor to visit. All scheduling outputs are registered.
module cargo_stop_scheduler (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_origem,
  input  logic [1:0] req_destino,
  output logic       req_ready,
  output logic       req_rejeitado,
  input  logic [1:0] andarAtual,
  input  logic       parada_concluida,
  output logic [1:0] proxParada,
  output logic       temDestino,
  output logic       sobe,
  output logic       eh_origem,
  output logic       eh_destino,
  output logic [2:0] ocupacao
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2
  } dir_t;

  // fase = 0: waiting for pickup at origem; fase = 1: loaded, heading to destino
  typedef struct packed {
    logic       valid;
    logic       fase;
    logic [1:0] origem;
    logic [1:0] destino;
  } entry_t;

  entry_t     tbl_q [4];
  entry_t     tbl_d [4];
  logic [2:0] occ_d;
  logic       service;
  logic       accept;
  logic       reject;
  logic       placed;

  dir_t       state_q;
  dir_t       state_d;

  logic [3:0] tgt_mask;
  logic [3:0] org_mask;
  logic [3:0] dst_mask;
  logic       any_tgt;
  logic       has_ge;
  logic       has_le;
  logic       has_lt;
  logic [1:0] min_ge;
  logic [1:0] max_le;
  logic [1:0] max_lt;
  logic [1:0] d_up;
  logic [1:0] d_dn;

  logic [1:0] prox_d;
  logic       tem_d;
  logic       sobe_d;
  logic       eho_d;
  logic       ehd_d;

  assign req_ready = (ocupacao < 3'd4);
  // A pulse with nothing scheduled is ignored entirely.
  assign service   = parada_concluida & temDestino;
  assign accept    = req_valid & req_ready & (req_origem != req_destino);
  assign reject    = req_valid & req_ready & (req_origem == req_destino);

  // Next table contents: service the current floor, then place any new order.
  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no latch is inferred; clocked blocks use non-blocking '<='.
  always_comb begin
    tbl_d  = tbl_q;
    placed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // Decisions are taken from the old fase, so a promotion and a
      // retirement can never both hit one entry on the same pulse.
      if (service && tbl_q[i].valid) begin
        if (!tbl_q[i].fase && tbl_q[i].origem == andarAtual)
          tbl_d[i].fase = 1'b1;
        else if (tbl_q[i].fase && tbl_q[i].destino == andarAtual)
          tbl_d[i].valid = 1'b0;
      end
    end
    // Free slots are judged on the old table, so a new order never lands in
    // a slot being serviced on this same edge and is not serviced by it.
    for (int i = 0; i < 4; i++) begin
      if (accept && !placed && !tbl_q[i].valid) begin
        tbl_d[i].valid   = 1'b1;
        tbl_d[i].fase    = 1'b0;
        tbl_d[i].origem  = req_origem;
        tbl_d[i].destino = req_destino;
        placed           = 1'b1;
      end
    end
  end

  // Occupancy of the next table, so ocupacao tracks the table edge for edge.
  always_comb begin
    occ_d = 3'd0;
    for (int i = 0; i < 4; i++)
      occ_d = occ_d + 3'(tbl_d[i].valid);
  end

  // Order table, occupancy and reject pulse registers.
  // NOTE: the table is only four entries of flops, so every field is reset
  // rather than just the valid bits; this keeps X out of the target masks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        tbl_q[i] <= '0;
      ocupacao      <= 3'd0;
      req_rejeitado <= 1'b0;
    end else begin
      tbl_q         <= tbl_d;
      ocupacao      <= occ_d;
      req_rejeitado <= reject;
    end
  end

  // Per-floor masks of pending targets, pickups and drops.
  always_comb begin
    tgt_mask = 4'b0;
    org_mask = 4'b0;
    dst_mask = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (tbl_q[i].valid) begin
        if (!tbl_q[i].fase) begin
          tgt_mask[tbl_q[i].origem] = 1'b1;
          org_mask[tbl_q[i].origem] = 1'b1;
        end else begin
          tgt_mask[tbl_q[i].destino] = 1'b1;
          dst_mask[tbl_q[i].destino] = 1'b1;
        end
      end
    end
  end

  // Nearest targets at/above and at/below the car.
  always_comb begin
    has_ge = 1'b0;
    has_le = 1'b0;
    has_lt = 1'b0;
    min_ge = 2'd0;
    max_le = 2'd0;
    max_lt = 2'd0;
    // Descending scan leaves the smallest qualifying floor.
    for (int f = 3; f >= 0; f--) begin
      if (tgt_mask[f] && 2'(f) >= andarAtual) begin
        has_ge = 1'b1;
        min_ge = 2'(f);
      end
    end
    // Ascending scan leaves the largest qualifying floor.
    for (int f = 0; f < 4; f++) begin
      if (tgt_mask[f] && 2'(f) <= andarAtual) begin
        has_le = 1'b1;
        max_le = 2'(f);
      end
      if (tgt_mask[f] && 2'(f) < andarAtual) begin
        has_lt = 1'b1;
        max_lt = 2'(f);
      end
    end
  end

  assign any_tgt = |tgt_mask;
  assign d_up    = min_ge - andarAtual;
  assign d_dn    = andarAtual - max_lt;

  // Direction FSM: state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  // Direction FSM: next state. Keep sweeping while targets lie ahead,
  // otherwise reverse; from idle head for the nearest target (ties go up).
  always_comb begin
    state_d = state_q;
    if (!any_tgt) begin
      state_d = OCIOSO;
    end else begin
      case (state_q)
        OCIOSO:   state_d = (has_ge && (!has_lt || d_up <= d_dn)) ? SUBINDO : DESCENDO;
        SUBINDO:  state_d = has_ge ? SUBINDO : DESCENDO;
        DESCENDO: state_d = has_le ? DESCENDO : SUBINDO;
        default:  state_d = OCIOSO;
      endcase
    end
  end

  // Direction FSM: output values for the next cycle. Going up always lands
  // on min_ge and going down on max_le: after a reversal the floor the car
  // sits on holds no target, so those equal the strict-inequality picks.
  always_comb begin
    prox_d = proxParada;
    tem_d  = 1'b0;
    sobe_d = 1'b0;
    case (state_d)
      SUBINDO: begin
        prox_d = min_ge;
        tem_d  = 1'b1;
        sobe_d = 1'b1;
      end
      DESCENDO: begin
        prox_d = max_le;
        tem_d  = 1'b1;
      end
      default: ;
    endcase
    eho_d = tem_d & org_mask[prox_d];
    ehd_d = tem_d & dst_mask[prox_d];
  end

  // Registered scheduling outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      proxParada <= 2'd0;
      temDestino <= 1'b0;
      sobe       <= 1'b0;
      eh_origem  <= 1'b0;
      eh_destino <= 1'b0;
    end else begin
      proxParada <= prox_d;
      temDestino <= tem_d;
      sobe       <= sobe_d;
      eh_origem  <= eho_d;
      eh_destino <= ehd_d;
    end
  end

endmodule
